fsm_eg_param: RTL and testbench

FSM_EG_PARAM -- requirements
Module: fsm_eg_param

---
 rtl/fsm_eg_param.sv | 98 +++++++++
 tb/tb_fsm_eg_param.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fsm_eg_param.sv
// Four-state controller that walks x/y counters, with a dwell limit that forces entry to S3.
// Latency: every output is a flop updated on the rising edge; there is no backpressure and no comb path from a/b.
module fsm_eg_param #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP       = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a,
    input  logic                  b,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic [1:0]            state_o,
    output logic                  timeout_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [DATA_WIDTH-1:0] STEP_W    = DATA_WIDTH'(STEP);
    localparam logic [CW-1:0]         DWELL_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         dwell_q, dwell_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic                  timeout_q, timeout_d;
    logic                  at_lim;

    assign at_lim = (dwell_q == DWELL_MAX);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        timeout_d = 1'b0;
        dwell_d   = '0;
        // Output action is selected by the current state, not the next one.
        case (state_q)
            S0: begin
                x_d = '0;
                y_d = '0;
                if (a) state_d = b ? S2 : S1;
            end
            S1: begin
                x_d = x_q + STEP_W;
                if (a)           state_d = b ? S2 : S0;
                else if (at_lim) state_d = S3;
            end
            S2: begin
                y_d = y_q + STEP_W;
                if (!b)          state_d = S0;
                else if (at_lim) state_d = S3;
            end
            S3: begin
                x_d = '1;
                y_d = '1;
                if (!a && !b) state_d = S0;
            end
            default: begin
                state_d = S0;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
        timeout_d = (state_d == S3) && ((state_q == S1) || (state_q == S2));
        if ((state_d == state_q) && ((state_q == S1) || (state_q == S2)))
            dwell_d = dwell_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S0;
            dwell_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            x_q       <= x_d;
            y_q       <= y_d;
            timeout_q <= timeout_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign state_o   = state_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_fsm_eg_param.sv
// Directed bench for fsm_eg_param: three parameterisations share clock and reset.
module tb_fsm_eg_param;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       a_d = 1'b0, b_d = 1'b0;
    logic [7:0] x_d, y_d;
    logic [1:0] st_d;
    logic       to_d;

    logic       a_t = 1'b0, b_t = 1'b0;
    logic [7:0] x_t, y_t;
    logic [1:0] st_t;
    logic       to_t;

    logic       a_s = 1'b0, b_s = 1'b0;
    logic [7:0] x_s, y_s;
    logic [1:0] st_s;
    logic       to_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fsm_eg_param u_def (
        .clk(clk), .rst_n(rst_n), .a(a_d), .b(b_d),
        .x(x_d), .y(y_d), .state_o(st_d), .timeout_o(to_d)
    );

    fsm_eg_param #(.DATA_WIDTH(8), .STEP(1), .TIMEOUT(4)) u_to4 (
        .clk(clk), .rst_n(rst_n), .a(a_t), .b(b_t),
        .x(x_t), .y(y_t), .state_o(st_t), .timeout_o(to_t)
    );

    fsm_eg_param #(.DATA_WIDTH(8), .STEP(8'h40), .TIMEOUT(8)) u_s40 (
        .clk(clk), .rst_n(rst_n), .a(a_s), .b(b_s),
        .x(x_s), .y(y_s), .state_o(st_s), .timeout_o(to_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        chk("rst_x", x_d, 8'h00);
        chk("rst_y", y_d, 8'h00);
        chk("rst_st", st_d, 2'd0);
        chk("rst_to", to_d, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rel_x", x_d, 8'h00);
        chk("rel_st", st_d, 2'd0);
        chk("rel_to", to_d, 1'b0);

        // S0 -> S1 -> S0 with defaults
        a_d = 1'b1; b_d = 1'b0; tick();
        chk("s1a_st", st_d, 2'd1); chk("s1a_x", x_d, 8'd0);
        a_d = 1'b0; tick();
        chk("s1b_st", st_d, 2'd1); chk("s1b_x", x_d, 8'd1);
        tick();
        chk("s1c_st", st_d, 2'd1); chk("s1c_x", x_d, 8'd2);
        a_d = 1'b1; tick();
        chk("s1d_st", st_d, 2'd0); chk("s1d_x", x_d, 8'd3);
        a_d = 1'b0; tick();
        chk("s1e_x", x_d, 8'd0);

        // Priority: a&b in S1 goes to S2
        a_d = 1'b1; b_d = 1'b0; tick();
        chk("pri_s1", st_d, 2'd1);
        b_d = 1'b1; tick();
        chk("pri_st", st_d, 2'd2); chk("pri_x", x_d, 8'd1);
        a_d = 1'b0; b_d = 1'b0; tick();
        chk("pri_s0", st_d, 2'd0); chk("pri_y", y_d, 8'd1);
        tick();
        chk("pri_clr_x", x_d, 8'd0); chk("pri_clr_y", y_d, 8'd0);

        // Timeout with TIMEOUT=4
        a_t = 1'b1; b_t = 1'b0; tick();
        chk("to_ent", st_t, 2'd1);
        a_t = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("to_x", x_t, 32'(i));
            chk("to_st", st_t, 2'd1);
            chk("to_pulse_lo", to_t, 1'b0);
        end
        tick();
        chk("to_x4", x_t, 8'd4);
        chk("to_s3", st_t, 2'd3);
        chk("to_pulse", to_t, 1'b1);
        tick();
        chk("to_ff_x", x_t, 8'hFF); chk("to_ff_y", y_t, 8'hFF);
        chk("to_pulse_end", to_t, 1'b0); chk("to_ret", st_t, 2'd0);
        tick();
        chk("to_clr", x_t, 8'h00);

        // S3 hold with a=1,b=0
        a_t = 1'b1; tick(); a_t = 1'b0;
        repeat (4) tick();
        chk("h_s3", st_t, 2'd3); chk("h_p", to_t, 1'b1);
        a_t = 1'b1; b_t = 1'b0; tick();
        chk("h_st", st_t, 2'd3); chk("h_to", to_t, 1'b0); chk("h_x", x_t, 8'hFF);
        tick();
        chk("h_st2", st_t, 2'd3); chk("h_to2", to_t, 1'b0);
        a_t = 1'b0; tick();
        chk("h_ret", st_t, 2'd0);

        // S2 wrap with STEP=0x40
        a_s = 1'b1; b_s = 1'b1; tick();
        chk("w_ent", st_s, 2'd2); chk("w_y0", y_s, 8'h00);
        a_s = 1'b0;
        chk_wrap();
        b_s = 1'b0; tick();
        chk("w_s0", st_s, 2'd0); chk("w_yl", y_s, 8'h80);
        tick();
        chk("w_clr", y_s, 8'h00);

        // Async reset mid-cycle in S2 with y=0x80
        a_s = 1'b1; b_s = 1'b1; tick();
        a_s = 1'b0; tick(); tick();
        chk("ar_pre_y", y_s, 8'h80); chk("ar_pre_st", st_s, 2'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_y", y_s, 8'h00); chk("ar_st", st_s, 2'd0); chk("ar_to", to_s, 1'b0);
        #1 rst_n = 1'b1;
        b_s = 1'b0; tick();
        chk("ar_post", st_s, 2'd0); chk("ar_post_y", y_s, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic chk_wrap();
        logic [7:0] exp_y [5];
        exp_y = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("w_y", y_s, exp_y[i]);
            chk("w_x", x_s, 8'h00);
            chk("w_st", st_s, 2'd2);
        end
    endtask

endmodule
